// File: rtl/vga_sync_controller.sv
// VGA timing generator: pixel/line counters, registered sync/active decode, line/frame pulses.
// Define VGA_SYNC_FRAME_COUNT_EN to add the 8-bit FrameCount output.
module vga_sync_controller #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       PixelTick,
   input  logic       Enable,
   output logic [9:0] PixelX,
   output logic [9:0] PixelY,
   output logic       HSync,
   output logic       VSync,
   output logic       DisplayActive,
   output logic       LineStart,
   output logic       FrameStart
`ifdef VGA_SYNC_FRAME_COUNT_EN
   ,
   output logic [7:0] FrameCount
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Last count of each region; a state is left on the advance out of its last count.
   localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FRONT - 1);
   localparam logic [9:0] H_SP_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FRONT - 1);
   localparam logic [9:0] V_SP_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {H_ACT, H_FP, H_SP, H_BP} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FP, V_SP, V_BP} v_state_t;

   h_state_t   h_state, h_next;
   v_state_t   v_state, v_next;
   logic [9:0] x_next, y_next;
   logic       advance, line_end;
   logic       hsync_next, vsync_next, active_next;
   logic       line_start_next, frame_start_next;

   // State register: counters and level outputs move only on an advance; pulses reload every edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         h_state       <= H_ACT;
         v_state       <= V_ACT;
         PixelX        <= '0;
         PixelY        <= '0;
         HSync         <= 1'b1;
         VSync         <= 1'b1;
         DisplayActive <= 1'b1;
         LineStart     <= 1'b0;
         FrameStart    <= 1'b0;
      end else begin
         LineStart  <= line_start_next;
         FrameStart <= frame_start_next;
         if (advance) begin
            h_state       <= h_next;
            v_state       <= v_next;
            PixelX        <= x_next;
            PixelY        <= y_next;
            HSync         <= hsync_next;
            VSync         <= vsync_next;
            DisplayActive <= active_next;
         end
      end
   end

   // Next-state logic for both counters and both region FSMs.
   always_comb begin
      advance  = PixelTick & Enable;
      line_end = (PixelX == H_LAST);
      h_next   = h_state;
      v_next   = v_state;
      x_next   = PixelX;
      y_next   = PixelY;
      if (advance) begin
         x_next = line_end ? '0 : PixelX + 10'd1;
         unique case (h_state)
            H_ACT:   if (PixelX == H_ACT_END) h_next = H_FP;
            H_FP:    if (PixelX == H_FP_END)  h_next = H_SP;
            H_SP:    if (PixelX == H_SP_END)  h_next = H_BP;
            H_BP:    if (line_end)            h_next = H_ACT;
            default:                          h_next = H_ACT;
         endcase
         if (line_end) begin
            y_next = (PixelY == V_LAST) ? '0 : PixelY + 10'd1;
            unique case (v_state)
               V_ACT:   if (PixelY == V_ACT_END) v_next = V_FP;
               V_FP:    if (PixelY == V_FP_END)  v_next = V_SP;
               V_SP:    if (PixelY == V_SP_END)  v_next = V_BP;
               V_BP:    if (PixelY == V_LAST)    v_next = V_ACT;
               default:                          v_next = V_ACT;
            endcase
         end
      end
   end

   // Output decode of the next state, so registered levels line up with the new counts.
   always_comb begin
      hsync_next       = (h_next != H_SP);
      vsync_next       = (v_next != V_SP);
      active_next      = (h_next == H_ACT) && (v_next == V_ACT);
      line_start_next  = advance && (x_next == '0);
      frame_start_next = line_start_next && (y_next == '0);
   end

`ifdef VGA_SYNC_FRAME_COUNT_EN
   // Counts on the same edge that raises FrameStart.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         FrameCount <= '0;
      end else if (frame_start_next) begin
         FrameCount <= FrameCount + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller: default-timing and tiny-timing instances checked against an
// advance-count model (position = ticks mod line/frame length). Honours VGA_SYNC_FRAME_COUNT_EN.
module tb_vga_sync_controller;

   localparam int HA_D = 640, HF_D = 16, HS_D = 96, HB_D = 48;
   localparam int VA_D = 480, VF_D = 10, VS_D = 2,  VB_D = 33;
   localparam int HT_D = HA_D + HF_D + HS_D + HB_D;
   localparam int VT_D = VA_D + VF_D + VS_D + VB_D;
   localparam int HA_S = 4, HF_S = 1, HS_S = 2, HB_S = 1;
   localparam int VA_S = 3, VF_S = 1, VS_S = 1, VB_S = 2;
   localparam int HT_S = HA_S + HF_S + HS_S + HB_S;
   localparam int VT_S = VA_S + VF_S + VS_S + VB_S;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       PixelTick, Enable;
   logic [9:0] d_x, d_y, s_x, s_y;
   logic       d_hs, d_vs, d_da, d_ls, d_fs;
   logic       s_hs, s_vs, s_da, s_ls, s_fs;
`ifdef VGA_SYNC_FRAME_COUNT_EN
   logic [7:0] d_fc, s_fc;
`endif

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   vga_sync_controller dut_d (
      .Clock(Clock), .Reset(Reset), .PixelTick(PixelTick), .Enable(Enable),
      .PixelX(d_x), .PixelY(d_y), .HSync(d_hs), .VSync(d_vs),
      .DisplayActive(d_da), .LineStart(d_ls), .FrameStart(d_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
      , .FrameCount(d_fc)
`endif
   );

   vga_sync_controller #(
      .H_ACTIVE(HA_S), .H_FRONT(HF_S), .H_SYNC(HS_S), .H_BACK(HB_S),
      .V_ACTIVE(VA_S), .V_FRONT(VF_S), .V_SYNC(VS_S), .V_BACK(VB_S)
   ) dut_s (
      .Clock(Clock), .Reset(Reset), .PixelTick(PixelTick), .Enable(Enable),
      .PixelX(s_x), .PixelY(s_y), .HSync(s_hs), .VSync(s_vs),
      .DisplayActive(s_da), .LineStart(s_ls), .FrameStart(s_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
      , .FrameCount(s_fc)
`endif
   );

   // Model state: total advances since reset, plus pulse flags and frame counts.
   longint n = 0;
   bit     ls_d = 0, fs_d = 0, ls_s = 0, fs_s = 0;
   int     fc_d = 0, fc_s = 0;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         n = 0; ls_d = 0; fs_d = 0; ls_s = 0; fs_s = 0; fc_d = 0; fc_s = 0;
      end else begin
         ls_d = 0; fs_d = 0; ls_s = 0; fs_s = 0;
         if (PixelTick && Enable) begin
            n++;
            ls_d = (n % HT_D) == 0;
            fs_d = (n % (HT_D * VT_D)) == 0;
            ls_s = (n % HT_S) == 0;
            fs_s = (n % (HT_S * VT_S)) == 0;
            if (fs_d) fc_d = (fc_d + 1) % 256;
            if (fs_s) fc_s = (fc_s + 1) % 256;
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_rng(input longint v, input int lo, input int len);
      return (v >= lo) && (v < lo + len);
   endfunction

   // Compare process: every cycle, both instances against the model.
   always @(negedge Clock) begin
      longint xd, yd, xs, ys;
      xd = n % HT_D; yd = (n / HT_D) % VT_D;
      xs = n % HT_S; ys = (n / HT_S) % VT_S;
      check("d.PixelX", d_x, xd);
      check("d.PixelY", d_y, yd);
      check("d.HSync", d_hs, !in_rng(xd, HA_D + HF_D, HS_D));
      check("d.VSync", d_vs, !in_rng(yd, VA_D + VF_D, VS_D));
      check("d.DisplayActive", d_da, (xd < HA_D) && (yd < VA_D));
      check("d.LineStart", d_ls, ls_d);
      check("d.FrameStart", d_fs, fs_d);
      check("s.PixelX", s_x, xs);
      check("s.PixelY", s_y, ys);
      check("s.HSync", s_hs, !in_rng(xs, HA_S + HF_S, HS_S));
      check("s.VSync", s_vs, !in_rng(ys, VA_S + VF_S, VS_S));
      check("s.DisplayActive", s_da, (xs < HA_S) && (ys < VA_S));
      check("s.LineStart", s_ls, ls_s);
      check("s.FrameStart", s_fs, fs_s);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      check("d.FrameCount", d_fc, fc_d);
      check("s.FrameCount", s_fc, fc_s);
`endif
   end

   // Present inputs, let one edge consume them, return just after that edge.
   task automatic drive(input bit t, input bit e);
      PixelTick = t;
      Enable    = e;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1; PixelTick = 1'b0; Enable = 1'b0;
      #1 Reset = 1'b0;
      #1;
      // Reset values with no clock edge yet.
      check("rst.PixelX", d_x, 0);
      check("rst.PixelY", d_y, 0);
      check("rst.HSync", d_hs, 1);
      check("rst.VSync", d_vs, 1);
      check("rst.DisplayActive", d_da, 1);
      check("rst.LineStart", d_ls, 0);
      check("rst.FrameStart", d_fs, 0);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      check("rst.FrameCount", d_fc, 0);
`endif
      @(posedge Clock); #1;
      drive(0, 0);
      Reset = 1'b1;

      // One full line, tick every second cycle.
      for (int i = 1; i <= 800; i++) begin
         drive(1, 1);
         if (i == 639) check("line.da_639", d_da, 1);
         if (i == 640) check("line.da_640", d_da, 0);
         if (i == 655) check("line.hs_655", d_hs, 1);
         if (i == 656) check("line.hs_656", d_hs, 0);
         if (i == 751) check("line.hs_751", d_hs, 0);
         if (i == 752) check("line.hs_752", d_hs, 1);
         if (i == 800) begin
            check("line.x_wrap", d_x, 0);
            check("line.y_inc", d_y, 1);
            check("line.ls_on", d_ls, 1);
         end
         drive(0, 1);
         if (i == 800) check("line.ls_off", d_ls, 0);
      end

      // Freeze at PixelX=300 with ticks still arriving.
      for (int i = 0; i < 300; i++) drive(1, 1);
      check("freeze.x_at", d_x, 300);
      for (int i = 0; i < 100; i++) drive(1, 0);
      check("freeze.x_held", d_x, 300);
      check("freeze.y_held", d_y, 1);
      check("freeze.ls", d_ls, 0);
      drive(1, 1);
      check("freeze.x_resume", d_x, 301);

      // Move to (700,3), then reset asynchronously mid-cycle.
      for (int i = 0; i < 1999; i++) drive(1, 1);
      check("mid.x", d_x, 700);
      check("mid.y", d_y, 3);
      #2 Reset = 1'b0;
      #1;
      check("mid.rst_x", d_x, 0);
      check("mid.rst_y", d_y, 0);
      check("mid.rst_hs", d_hs, 1);
      check("mid.rst_da", d_da, 1);
      drive(1, 1);
      drive(1, 1);
      Reset = 1'b1;
      drive(1, 1);
      check("mid.first_x", d_x, 1);
      check("mid.first_y", d_y, 0);
      check("mid.first_sx", s_x, 1);
      check("mid.first_sy", s_y, 0);

      // Randomized ticks and enables.
      for (int i = 0; i < 20000; i++) drive(1'($urandom % 2), ($urandom % 5) != 0);
      // Back-to-back ticks.
      for (int i = 0; i < 2000; i++) drive(1, 1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
      // Enough frames on the tiny instance to wrap FrameCount.
      for (int i = 0; i < 15000; i++) drive(1, ($urandom % 8) != 0);
`endif
      drive(0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_sync_controller.md
VGA_SYNC_CONTROLLER -- requirements
Module: vga_sync_controller

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, HSync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 10, 2 and 33, vertical porches/pulse in lines.
REQ-007 Clock  input  1  system clock; the only clock.
REQ-008 Reset  input  1  asynchronous, active-low reset.
REQ-009 PixelTick  input  1  one-Clock-wide pixel-rate strobe from the CRT clock generator (25 MHz rate).
REQ-010 Enable  input  1  1 = timing advances, 0 = freeze.
REQ-011 PixelX  output  10  current horizontal count, 0..H_total-1.
REQ-012 PixelY  output  10  current vertical count, 0..V_total-1.
REQ-013 HSync  output  1  horizontal sync, active-low.
REQ-014 VSync  output  1  vertical sync, active-low.
REQ-015 DisplayActive  output  1  1 when PixelX<H_ACTIVE and PixelY<V_ACTIVE.
REQ-016 LineStart  output  1  one-Clock pulse when PixelX wraps to 0.
REQ-017 FrameStart  output  1  one-Clock pulse when PixelX and PixelY both wrap to 0.

Function
REQ-018 Advance: only on a rising Clock edge with PixelTick=1 and Enable=1; all other edges hold counters and level outputs.
REQ-019 H_total = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_total = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525); both SHALL be <=1024.
REQ-020 Horizontal FSM states: H_ACT (0..639), H_FP (640..655), H_SP (656..751), H_BP (752..799); transition at each boundary on an advance.
REQ-021 Vertical FSM states: V_ACT (0..479), V_FP (480..489), V_SP (490..491), V_BP (492..524); vertical state/count changes only on an advance where PixelX = H_total-1.
REQ-022 Wrap: PixelX = H_total-1 -> 0 and PixelY increments; additionally PixelY = V_total-1 -> 0.
REQ-023 HSync/VSync/DisplayActive SHALL be registered, loaded on each advance with the decode of the new counts; zero decode latency relative to PixelX/PixelY.
REQ-024 HSync=0 exactly while in H_SP; VSync=0 exactly while in V_SP (whole lines).
REQ-025 LineStart=1 for the single Clock cycle following the advance into PixelX=0; FrameStart likewise for advance into (0,0); both 0 otherwise, including while frozen.
REQ-026 Enable deasserted mid-line: counts, syncs, DisplayActive hold; resumption continues from held position, no skipped or repeated pixel.
REQ-027 PixelTick asserted for consecutive cycles: each cycle is a separate advance.

Reset
REQ-028 Reset=0 SHALL asynchronously force PixelX=0, PixelY=0, HSync=1, VSync=1, DisplayActive=1, LineStart=0, FrameStart=0, regardless of Clock.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the first advance moves to PixelX=1, PixelY=0.

Configuration
REQ-030 Macro VGA_SYNC_FRAME_COUNT_EN defined: adds output FrameCount (8 bits, reset 0), incremented with each FrameStart, wrapping 255 -> 0.
REQ-031 Macro undefined: no FrameCount port, no counter logic; all other behaviour identical.

Verification
REQ-032 Reset low, no clock edges -> PixelX=0, PixelY=0, HSync=1, VSync=1, DisplayActive=1, pulses 0.
REQ-033 Enable=1, PixelTick every 2nd cycle, 800 ticks -> HSync low for ticks 656..751 (96 ticks), DisplayActive 0 from tick 640, LineStart one cycle after tick 800, PixelY=1.
REQ-034 420000 ticks -> VSync low exactly during PixelY 490..491, FrameStart single pulse at (0,0), DisplayActive never 1 for PixelY>=480.
REQ-035 At PixelX=300 drop Enable for 100 ticks -> PixelX stays 300, no pulses; re-enable -> next advance gives 301.
REQ-036 Reset pulsed low at PixelY=200, PixelX=700 -> immediate reset values without clock edge; first advance after release -> (1,0).
REQ-037 With VGA_SYNC_FRAME_COUNT_EN, 256 frames -> FrameCount 0,1..255,0; without macro -> port absent, REQ-033..036 still pass.
